// File: rtl/sbox_lut_ctrl_if.sv
// S-box controller bus: table-write config, permutation handshake and datapath controls.
// The master modport drives requests; the slave modport is the controller.
interface sbox_lut_ctrl_if;
  logic        cfg_valid_i;
  logic [4:0]  cfg_addr_i;
  logic [20:0] cfg_data_i;
  logic        cfg_ready_o;
  logic        perm_req_i;
  logic [3:0]  perm_rounds_i;
  logic        perm_ack_o;
  logic        perm_busy_o;
  logic        perm_done_o;
  logic        state_en_o;
  logic [3:0]  round_idx_o;
  logic        upd_sbox_o;
  logic [4:0]  sbox_addr_o;
  logic [20:0] sbox_new_data_o;

  modport master (
    output cfg_valid_i, cfg_addr_i, cfg_data_i, perm_req_i, perm_rounds_i,
    input  cfg_ready_o, perm_ack_o, perm_busy_o, perm_done_o, state_en_o,
    input  round_idx_o, upd_sbox_o, sbox_addr_o, sbox_new_data_o
  );

  modport slave (
    input  cfg_valid_i, cfg_addr_i, cfg_data_i, perm_req_i, perm_rounds_i,
    output cfg_ready_o, perm_ack_o, perm_busy_o, perm_done_o, state_en_o,
    output round_idx_o, upd_sbox_o, sbox_addr_o, sbox_new_data_o
  );
endinterface

// File: rtl/sbox_lut_ctrl.sv
// S-box table-write and permutation round sequencer; ready/ack are combinational, all else registered.
// Table writes win over permutation requests in IDLE; both are ignored while a write or permutation runs.
module sbox_lut_ctrl #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic            clk,
  input  logic            rst,
  sbox_lut_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, UPDATE, ROUND, DONE} state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_ROUNDS);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_remain, w_remain_nxt;
  logic        r_state_en, w_state_en_nxt;
  logic [3:0]  r_round_idx, w_round_idx_nxt;
  logic        r_done, w_done_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_upd, w_upd_nxt;
  logic [4:0]  r_addr, w_addr_nxt;
  logic [20:0] r_data, w_data_nxt;
  logic        w_ack;
  logic [3:0]  w_rounds_clamped;

  assign w_rounds_clamped = (bus.perm_rounds_i > LP_MAX) ? LP_MAX : bus.perm_rounds_i;

  // Registered outputs are computed for the state being entered, so they line up with it.
  always_comb begin
    w_state_nxt     = r_state;
    w_remain_nxt    = r_remain;
    w_state_en_nxt  = 1'b0;
    w_round_idx_nxt = 4'd0;
    w_done_nxt      = 1'b0;
    w_busy_nxt      = 1'b0;
    w_upd_nxt       = 1'b0;
    w_addr_nxt      = 5'd0;
    w_data_nxt      = 21'd0;
    w_ack           = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cfg_valid_i) begin
          w_state_nxt = UPDATE;
          w_upd_nxt   = 1'b1;
          w_addr_nxt  = bus.cfg_addr_i;
          w_data_nxt  = bus.cfg_data_i;
        end else if (bus.perm_req_i) begin
          w_ack      = 1'b1;
          w_busy_nxt = 1'b1;
          if (w_rounds_clamped == 4'd0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt     = ROUND;
            w_state_en_nxt  = 1'b1;
            w_round_idx_nxt = LP_MAX - w_rounds_clamped;
            w_remain_nxt    = w_rounds_clamped - 4'd1;
          end
        end
      end
      UPDATE: begin
        w_state_nxt = IDLE;
      end
      ROUND: begin
        w_busy_nxt = 1'b1;
        if (r_remain == 4'd0) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_en_nxt  = 1'b1;
          w_round_idx_nxt = r_round_idx + 4'd1;
          w_remain_nxt    = r_remain - 4'd1;
        end
      end
      DONE: begin
        w_state_nxt  = IDLE;
        w_remain_nxt = 4'd0;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_remain_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remain    <= 4'd0;
      r_state_en  <= 1'b0;
      r_round_idx <= 4'd0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_upd       <= 1'b0;
      r_addr      <= 5'd0;
      r_data      <= 21'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_remain    <= w_remain_nxt;
      r_state_en  <= w_state_en_nxt;
      r_round_idx <= w_round_idx_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_upd       <= w_upd_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
    end
  end

  assign bus.cfg_ready_o     = (r_state == IDLE);
  assign bus.perm_ack_o      = w_ack;
  assign bus.perm_busy_o     = r_busy;
  assign bus.perm_done_o     = r_done;
  assign bus.state_en_o      = r_state_en;
  assign bus.round_idx_o     = r_round_idx;
  assign bus.upd_sbox_o      = r_upd;
  assign bus.sbox_addr_o     = r_addr;
  assign bus.sbox_new_data_o = r_data;

endmodule

// File: doc/sbox_lut_ctrl.md
SBOX_LUT_CTRL -- requirements
Module: sbox_lut_ctrl

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 12, meaning the maximum permutation rounds per request.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port cfg_valid_i, input, 1, an S-box table write request.
REQ-005 SHALL have port cfg_addr_i, input, 5, the table entry index.
REQ-006 SHALL have port cfg_data_i, input, 21, the table entry payload.
REQ-007 SHALL have port cfg_ready_o, output, 1, the write accepted this cycle when high together with cfg_valid_i.
REQ-008 SHALL have port perm_req_i, input, 1, a permutation request, held until acknowledged.
REQ-009 SHALL have port perm_rounds_i, input, 4, the requested round count, sampled at acknowledge.
REQ-010 SHALL have port perm_ack_o, output, 1, a one-cycle pulse that accepts perm_req_i.
REQ-011 SHALL have port perm_busy_o, output, 1, high from the cycle after acknowledge through the done cycle.
REQ-012 SHALL have port perm_done_o, output, 1, a one-cycle completion pulse.
REQ-013 SHALL have port state_en_o, output, 1, the load enable for the datapath state register after the substitution layer.
REQ-014 SHALL have port round_idx_o, output, 4, the round-constant index for the current round.
REQ-015 SHALL have port upd_sbox_o, output, 1, the table write strobe to the substitution layer.
REQ-016 SHALL have port sbox_addr_o, output, 5, the table write address.
REQ-017 SHALL have port sbox_new_data_o, output, 21, the table write data.

Function
REQ-018 SHALL implement FSM states IDLE, UPDATE, ROUND and DONE, with all outputs except cfg_ready_o/perm_ack_o registered.
REQ-019 SHALL drive cfg_ready_o = (state==IDLE) combinationally, giving at most one write accepted per two cycles.
REQ-020 SHALL, in IDLE with cfg_valid_i=1: capture cfg_addr_i/cfg_data_i, go to UPDATE, and raise upd_sbox_o=1 with the captured addr/data for exactly that one UPDATE cycle.
REQ-021 SHALL return from UPDATE to IDLE unconditionally; cfg_valid_i in UPDATE is not accepted.
REQ-022 SHALL, in IDLE with perm_req_i=1 and cfg_valid_i=0: pulse perm_ack_o combinationally, latch N=perm_rounds_i, and go to ROUND (N>=1) or DONE (N=0).
REQ-023 SHALL give a simultaneous cfg_valid_i and perm_req_i in IDLE priority to the config write; perm_ack_o stays 0 and the request stays pending.
REQ-024 SHALL clamp N values greater than MAX_ROUNDS to MAX_ROUNDS.
REQ-025 SHALL, in ROUND, assert state_en_o=1 every cycle for exactly N cycles with round_idx_o = MAX_ROUNDS - N + r, r = 0..N-1, then enter DONE.
REQ-026 SHALL hold upd_sbox_o=0 throughout ROUND and DONE so the substitution layer addresses from state bits; a table write never overlaps a round.
REQ-027 SHALL, in DONE, assert perm_done_o=1 for one cycle with state_en_o=0, then return to IDLE.
REQ-028 SHALL meet this latency: acknowledge in cycle T, state_en_o in T+1..T+N, perm_done_o in T+N+1; perm_busy_o high T+1..T+N+1.
REQ-029 SHALL ignore cfg_valid_i and perm_req_i while busy; cfg_ready_o=0 and perm_ack_o=0 in that period.
REQ-030 SHALL drive round_idx_o=0 outside ROUND and sbox_addr_o/sbox_new_data_o=0 outside UPDATE.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-ROUND or mid-UPDATE, immediately force the FSM to IDLE and all registered outputs and internal counters to 0.
REQ-032 SHALL NOT complete an interrupted permutation or write after reset release; no perm_done_o pulse is generated.
REQ-033 SHALL accept a request in the first cycle after rst deasserts.

Verification
REQ-034 SHALL cover: cfg write addr=5'h13 data=21'h1ABCDE -> one cycle later upd_sbox_o=1, sbox_addr_o=13h, sbox_new_data_o=1ABCDEh for exactly one cycle.
REQ-035 SHALL cover: perm_req_i with rounds=6 -> ack at T, state_en_o T+1..T+6 with round_idx_o 6,7,8,9,10,11, perm_done_o at T+7.
REQ-036 SHALL cover: simultaneous cfg_valid_i and perm_req_i (rounds=12) -> write first, ack two cycles later, round_idx_o 0..11.
REQ-037 SHALL cover: rounds=0 -> done at T+1 with no state_en_o; rounds=15 -> clamped to 12 rounds.
REQ-038 SHALL cover: rst pulse during round 3 of 12 -> all outputs 0 at once, no perm_done_o, and a new request is acknowledged the cycle after release.
REQ-039 SHALL cover: 32 back-to-back cfg writes -> accepted every 2nd cycle, upd_sbox_o never high while perm_busy_o=1.
